sync_fifo_v2: RTL and testbench

Parametrised single-clock FIFO. It is the next-generation replacement for the team's basic synchronous FIFO and is used as the general-purpose buffer between streaming blocks in the same clock domain. It adds full and empty protection, a full-range occupancy count, almost-full and almost-empty thresholds, overflow and underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_ram.sv | 56 +++++
 rtl/sync_fifo_v2.sv | 151 +++++++++++++++
 tb/tb_sync_fifo_v2.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the sync_fifo_v2 family.
package sync_fifo_pkg;

    // Default almost-empty level, and the distance below DEPTH for almost-full.
    localparam int DEF_AEMPTY_THRESH = 2;
    localparam int DEF_AFULL_MARGIN  = 2;

    // Number of words addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Width needed to hold an occupancy of 0..DEPTH inclusive.
    function automatic int count_width(input int addr_width);
        return $clog2((1 << addr_width) + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_v2: one synchronous write port and
// one read port feeding a reset-able output register. In FWFT mode the read
// side can bypass the array and take the word currently being written.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  bypass,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // The array itself is never reset; only the output register is.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_q;

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous array read; the bypass only exists in FWFT mode, where a
    // word written into an otherwise-empty head slot must appear next cycle.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((FWFT != 0) && bypass) begin
            rd_word = wr_data;
        end
    end

    // Output register: loaded only when the read side asks for a new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= rd_word;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty levels,
// overflow/underflow pulses and an optional first-word-fall-through read mode.
//
// Request semantics: wr_en offers din and is taken in a cycle where the FIFO
// is not full or a read is taken in that same cycle; rd_en is taken whenever
// the FIFO is not empty (a same-cycle write into an empty FIFO never makes a
// read legal). A request that is not taken leaves all state untouched and
// raises overflow/underflow for exactly the following cycle.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - DEF_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]         AFULL_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]         AEMPTY_C   = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic                  ram_rd_en;
    logic                  ram_bypass;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Status flags are pure decodes of the registered count.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);
    end

    // Acceptance: a read needs data already stored; a write needs a free slot
    // or a slot being freed by a read in the same cycle.
    always_comb begin
        rd_acc = rd_en && !empty;
        wr_acc = wr_en && (!full || rd_acc);
    end

    // Next occupancy: simultaneous read and write cancel out.
    always_comb begin
        count_next = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + CNT_ONE;
            2'b01:   count_next = count_q - CNT_ONE;
            default: count_next = count_q;
        endcase
    end

    // Read-side control of the memory output register. In standard mode it
    // fetches the head on each accepted read. In FWFT mode it always tracks
    // what the head will be after this edge: the next stored word after a
    // pop, din when that word is being written this cycle, and it holds its
    // old value once the FIFO goes empty.
    always_comb begin
        ram_rd_addr = rd_ptr;
        ram_rd_en   = rd_acc;
        ram_bypass  = 1'b0;
        if (FWFT != 0) begin
            ram_rd_addr = rd_acc ? (rd_ptr + PTR_ONE) : rd_ptr;
            ram_bypass  = wr_acc && ((count_q == '0) || ((count_q == CNT_ONE) && rd_acc));
            ram_rd_en   = (count_next != '0);
        end
    end

    // Pointers and count; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_next;
        end
    end

    // Registered one-cycle indications: read completion and rejected requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            valid_q     <= rd_acc;
            overflow_q  <= wr_en && !wr_acc;
            underflow_q <= rd_en && !rd_acc;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .bypass  (ram_bypass),
        .rd_data (ram_rd_data)
    );

    assign dout      = ram_rd_data;
    assign valid     = (FWFT != 0) ? !empty : valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: a standard-mode and an FWFT-mode instance share the
// same stimulus and are compared each cycle against a queue-based model.
module tb_sync_fifo_v2;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;

    logic [DW-1:0] dout0, dout1;
    logic          valid0, valid1;
    logic          full0, full1, empty0, empty1;
    logic          afull0, afull1, aempty0, aempty1;
    logic [AW:0]   count0, count1;
    logic          ovf0, ovf1, unf0, unf1;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dout0;
    logic          exp_valid0;
    logic [DW-1:0] exp_dout1;
    logic          exp_ovf;
    logic          exp_unf;

    sync_fifo_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut_std (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout0), .valid(valid0), .full(full0), .empty(empty0),
        .almost_full(afull0), .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout1), .valid(valid1), .full(full1), .empty(empty1),
        .almost_full(afull1), .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout0  = '0;
        exp_valid0 = 1'b0;
        exp_dout1  = '0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
    endtask

    // One clock of FIFO behaviour expressed with a queue.
    task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d);
        bit ra, wa;
        ra = r && (exp_q.size() > 0);
        wa = w && ((exp_q.size() < DEPTH) || ra);
        exp_ovf    = w && !wa;
        exp_unf    = r && !ra;
        exp_valid0 = ra;
        if (ra) exp_dout0 = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        if (exp_q.size() > 0) exp_dout1 = exp_q[0];
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        chk("count_std",   32'(count0),  32'(n));
        chk("count_fwft",  32'(count1),  32'(n));
        chk("empty_std",   32'(empty0),  32'(n == 0));
        chk("empty_fwft",  32'(empty1),  32'(n == 0));
        chk("full_std",    32'(full0),   32'(n == DEPTH));
        chk("full_fwft",   32'(full1),   32'(n == DEPTH));
        chk("afull_std",   32'(afull0),  32'(n >= DEPTH - 2));
        chk("afull_fwft",  32'(afull1),  32'(n >= DEPTH - 2));
        chk("aempty_std",  32'(aempty0), 32'(n <= 2));
        chk("aempty_fwft", 32'(aempty1), 32'(n <= 2));
        chk("ovf_std",     32'(ovf0),    32'(exp_ovf));
        chk("ovf_fwft",    32'(ovf1),    32'(exp_ovf));
        chk("unf_std",     32'(unf0),    32'(exp_unf));
        chk("unf_fwft",    32'(unf1),    32'(exp_unf));
        chk("valid_std",   32'(valid0),  32'(exp_valid0));
        chk("dout_std",    32'(dout0),   32'(exp_dout0));
        chk("valid_fwft",  32'(valid1),  32'(n > 0));
        chk("dout_fwft",   32'(dout1),   32'(exp_dout1));
    endtask

    // Driver: apply one cycle of inputs, advance the model, check outputs.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        model_step(w, r, d);
        #1;
        check_all();
    endtask

    initial begin : stim
        int wr_cnt, rd_cnt, guard;
        logic w, r;

        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        model_reset();

        // Reset state.
        #12;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill 0x00..0x0F, then overfill.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        chk("fill_full", 32'(full0), 32'd1);
        step(1'b1, 1'b0, 8'h77);
        chk("overfill_ovf", 32'(ovf0), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        chk("ovf_pulse_end", 32'(ovf0), 32'd0);

        // Drain 16 words, then one read too many.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        chk("drain_last", 32'(dout0), 32'h0F);
        step(1'b0, 1'b1, 8'h00);
        chk("underflow_hold", 32'(dout0), 32'h0F);

        // Empty boundary: write accepted, read rejected.
        step(1'b1, 1'b1, 8'h33);
        chk("empty_both_unf", 32'(unf0), 32'd1);

        // Refill to full, then full boundary with 0xAA.
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
        step(1'b1, 1'b1, 8'hAA);
        chk("full_both_cnt", 32'(count0), 32'd16);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        chk("aa_read_last", 32'(dout0), 32'hAA);

        // FWFT fall-through on an empty FIFO.
        step(1'b1, 1'b0, 8'h5A);
        chk("fwft_fallthru", 32'(dout1), 32'h5A);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("fwft_pop_valid", 32'(valid1), 32'd0);

        // Wrap-around with occupancy held within 3..12.
        wr_cnt = 0;
        rd_cnt = 0;
        guard  = 0;
        while ((wr_cnt < 40 || rd_cnt < 40) && guard < 400) begin
            if (exp_q.size() <= 3) begin
                w = 1'b1; r = 1'b0;
            end else if (exp_q.size() >= 12) begin
                w = 1'b0; r = 1'b1;
            end else begin
                w = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end
            if (w) wr_cnt++;
            if (r) rd_cnt++;
            step(w, r, DW'($urandom));
            guard++;
        end
        chk("wrap_budget", 32'(guard < 400), 32'd1);

        // Unconstrained random traffic reaching both boundaries.
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 75 : 25));
            r = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 25 : 75));
            step(w, r, DW'($urandom));
        end

        // Reset mid-stream at count=5, checked before any clock edge.
        guard = 0;
        while (exp_q.size() != 5 && guard < 64) begin
            if (exp_q.size() > 5) step(1'b0, 1'b1, 8'h00);
            else step(1'b1, 1'b0, DW'($urandom));
            guard++;
        end
        chk("pre_reset_cnt", 32'(count0), 32'd5);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First edges after release accept writes normally.
        step(1'b1, 1'b0, 8'hC3);
        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
